fifo_rd_packer: RTL and testbench
=================================

# fifo_rd_packer

Read-side consumer for the team's asynchronous FIFO, running entirely in the read clock domain. It pops bytes through the FIFO's `rempty`/`rinc`/`rd_data` read port and packs them little-endian into `BYTES`-wide words. Words are presented downstream on a valid/ready handshake. It is the counterpart of the write-side producer: the writer fills the FIFO in `wclk`, and this block drains it in `rclk`.

## Interface
- `BYTES`, 4: bytes per output word; legal range 2..8.
- `TIMEOUT`, 16: idle `rclk` cycles before a partial word is flushed; legal range 2..255. Used only with `FIFO_RD_PACK_TIMEOUT_EN`.
- `rclk`  in  1: read-domain clock; all logic on the rising edge.
- `rrst_n`  in  1: synchronous, active-low reset (sampled on `rclk` rising edge).
- `rempty`  in  1: FIFO empty flag.
- `rd_data`  in  8: FIFO head byte; valid whenever `rempty`=0 (show-ahead).
- `rinc`  out  1: pop request; combinational.
- `out_data`  out  8*BYTES: packed word; byte 0 in bits [7:0].
- `out_be`  out  BYTES: per-byte valid mask for `out_data`.
- `out_valid`  out  1: output word available.
- `out_ready`  in  1: downstream accepts the word.

## Operation
- A pop occurs at a rising edge when `rinc`=1. `rinc` = `rrst_n` & !`rempty` & (`idx` < `BYTES`) & !`flush_pend`. It is never 1 while `rempty`=1.
- Accumulator `acc` (`BYTES` bytes) and index `idx` (0..`BYTES`). A popped byte is written to `acc[idx]`, and `idx` increments.
- Slot free = (`out_valid`=0) | (`out_ready`=1).
- **Completing pop** (the pop with `idx`=`BYTES`-1):
  - Slot free: the word, including the new byte, loads directly into `out_data`; `out_be` = all-ones, `out_valid`=1, `idx`=0.
  - Slot not free: `acc` holds the full word with `idx`=`BYTES`; `rinc`=0.
- **Held full word:** at the first edge with slot free, it transfers to the output register and `idx`=0. No pop occurs on that edge.
- **Handshake:**
  - A word is consumed at an edge with `out_valid`=1 and `out_ready`=1.
  - `out_data` and `out_be` stay stable while `out_valid`=1 and `out_ready`=0.
  - If no new word loads at the consuming edge, `out_valid` drops to 0.
- **Output mux:** unused `out_data` bytes are driven 0. `out_data` and `out_be` read 0 while `out_valid`=0.
- **Mid-operation reset:** any partial word in `acc` is discarded. A presented word is dropped (`out_valid`=0) without a handshake. FIFO contents are untouched.
- **Arithmetic:** `idx` is `$clog2(BYTES+1)` bits. The timeout counter is 8 bits and saturates at `TIMEOUT`.

## Timing
- Reset values (the edge with `rrst_n`=0): `out_valid`=0, `out_data`=0, `out_be`=0, `idx`=0, timeout counter 0, `flush_pend`=0.
- `rinc`=0 combinationally while `rrst_n`=0.
- Latency: `out_valid` is high in the cycle after the edge of the completing pop, when the slot is free.
- Throughput: with the FIFO non-empty and `out_ready` held at 1, the block pops 1 byte per cycle and produces 1 word every `BYTES` cycles with no bubbles.
- Backpressure: a held full word adds at least 1 cycle (the transfer edge) before popping resumes.

## Configuration
- `FIFO_RD_PACK_TIMEOUT_EN` defined:
  - The counter increments on each edge with 0 < `idx` < `BYTES`, no pop, and `flush_pend`=0. It clears on any pop and when `idx`=0.
  - When the counter reaches `TIMEOUT`, `flush_pend` is set and `rinc` is forced to 0.
  - At the first edge with slot free, the partial word loads: `out_be` has the low `idx` bits set, and the remaining bytes are 0. Then `idx`=0, the counter is 0, and `flush_pend`=0.
- `FIFO_RD_PACK_TIMEOUT_EN` undefined:
  - There is no counter and no flush; a partial word waits indefinitely for more bytes.
  - `out_be` is all-ones whenever `out_valid`=1.

## Test plan
- **Reset:** hold `rrst_n`=0 with `rempty`=0 for 3 cycles -> `rinc`=0, `out_valid`=0, `out_data`=0, `out_be`=0.
- **Streaming:** `BYTES`=4, FIFO preloaded 0x01..0x08, `out_ready`=1 -> words 0x04030201 then 0x08070605 in consecutive 4-cycle groups; `rinc` high 8 consecutive cycles; `out_be`=0xF.
- **Backpressure:** `out_ready`=0 with 12 bytes queued -> first word held stable; second word stalls in `acc` with `rinc`=0. Raise `out_ready` -> words delivered in order, with no loss or duplication.
- **Empty gaps:** `rempty` toggled randomly, 1 in 3 cycles, feeding 0x10..0x1F -> `rinc` never asserted while `rempty`=1; output words 0x13121110, 0x17161514, 0x1B1A1918, 0x1F1E1D1C.
- **Timeout** (`FIFO_RD_PACK_TIMEOUT_EN`, `TIMEOUT`=16): 3 bytes 0xAA, 0xBB, 0xCC, then the FIFO stays empty -> 16 idle cycles later `out_data`=0x00CCBBAA, `out_be`=0x7. Without the macro, no output appears after 100 cycles.
- **Mid-word reset:** reset after 2 bytes of a word, then feed 0x21..0x24 -> first output is exactly 0x24232221.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// Read-side packer: pops bytes from the async FIFO read port and packs them into little-endian words.
// Optional partial-word flush on idle timeout is enabled by defining FIFO_RD_PACK_TIMEOUT_EN.
module fifo_rd_packer #(
  parameter int BYTES   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic               rclk,
  input  logic               rrst_n,
  input  logic               rempty,
  input  logic [7:0]         rd_data,
  output logic               rinc,
  output logic [8*BYTES-1:0] out_data,
  output logic [BYTES-1:0]   out_be,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int IW = $clog2(BYTES + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(BYTES - 1);
  localparam logic [IW-1:0] IDX_FULL = IW'(BYTES);

  logic [IW-1:0]      idx;
  logic [8*BYTES-1:0] acc;
  logic [8*BYTES-1:0] acc_ins;
  logic [8*BYTES-1:0] word_q;
  logic [BYTES-1:0]   be_q;
  logic               valid_q;
  logic               flush_pend;
  logic               slot_free;
  logic               pop;
  logic               full_held;

  assign slot_free = ~valid_q | out_ready;
  assign full_held = (idx == IDX_FULL);
  assign rinc      = rrst_n & ~rempty & (idx < IDX_FULL) & ~flush_pend;
  assign pop       = rinc;

  // accumulator with the incoming byte already placed at idx
  always_comb begin
    acc_ins = acc;
    for (int i = 0; i < BYTES; i++) begin
      if (idx == IW'(i)) acc_ins[8*i +: 8] = rd_data;
    end
  end

`ifdef FIFO_RD_PACK_TIMEOUT_EN
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  logic [7:0]         tmo_cnt;
  logic [8*BYTES-1:0] part_data;
  logic [BYTES-1:0]   part_be;

  always_comb begin
    part_data = '0;
    part_be   = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (IW'(i) < idx) begin
        part_data[8*i +: 8] = acc[8*i +: 8];
        part_be[i]          = 1'b1;
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      tmo_cnt    <= '0;
      flush_pend <= 1'b0;
    end else if (flush_pend) begin
      if (slot_free) begin
        tmo_cnt    <= '0;
        flush_pend <= 1'b0;
      end
    end else if (pop || idx == '0) begin
      tmo_cnt <= '0;
    end else if (!full_held && tmo_cnt != TMO) begin
      tmo_cnt <= tmo_cnt + 8'd1;
      if (tmo_cnt + 8'd1 == TMO) flush_pend <= 1'b1;
    end
  end
`else
  assign flush_pend = 1'b0;
`endif

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      idx     <= '0;
      acc     <= '0;
      word_q  <= '0;
      be_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      if (valid_q && out_ready) valid_q <= 1'b0;
      // a held full word has priority; popping resumes on the following edge
      if (full_held && slot_free) begin
        word_q  <= acc;
        be_q    <= '1;
        valid_q <= 1'b1;
        idx     <= '0;
      end
`ifdef FIFO_RD_PACK_TIMEOUT_EN
      else if (flush_pend && slot_free) begin
        word_q  <= part_data;
        be_q    <= part_be;
        valid_q <= 1'b1;
        idx     <= '0;
      end
`endif
      else if (pop) begin
        acc <= acc_ins;
        if (idx == IDX_LAST) begin
          if (slot_free) begin
            word_q  <= acc_ins;
            be_q    <= '1;
            valid_q <= 1'b1;
            idx     <= '0;
          end else begin
            idx <= IDX_FULL;
          end
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = valid_q ? word_q : '0;
  assign out_be    = valid_q ? be_q : '0;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a queue-based FIFO model and output capture.
module tb_fifo_rd_packer;

  localparam int BYTES   = 4;
  localparam int TIMEOUT = 16;

  logic        rclk      = 1'b0;
  logic        rrst_n    = 1'b0;
  logic        rempty    = 1'b1;
  logic [7:0]  rd_data   = 8'h00;
  logic        rinc;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int viol  = 0;
  bit gap_mode = 1'b0;

  logic [7:0]  fifo_q[$];
  logic [31:0] rx_data[$];
  logic [3:0]  rx_be[$];
  int          rx_cyc[$];
  int          pop_cyc[$];

  always #5 rclk = ~rclk;

  fifo_rd_packer #(.BYTES(BYTES), .TIMEOUT(TIMEOUT)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rempty    (rempty),
    .rd_data   (rd_data),
    .rinc      (rinc),
    .out_data  (out_data),
    .out_be    (out_be),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // observe pops and accepted words at the edge
  always @(posedge rclk) begin
    cyc++;
    if (rinc) begin
      if (rempty) viol++;
      pop_cyc.push_back(cyc);
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    if (out_valid && out_ready) begin
      rx_data.push_back(out_data);
      rx_be.push_back(out_be);
      rx_cyc.push_back(cyc);
    end
  end

  // FIFO read port model, updated shortly after each edge
  always begin
    @(posedge rclk);
    #2;
    rempty  = (fifo_q.size() == 0) || (gap_mode && ($urandom_range(0, 2) == 0));
    rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  task automatic step(input int n);
    repeat (n) @(negedge rclk);
  endtask

  task automatic hold_reset();
    @(negedge rclk);
    rrst_n    = 1'b0;
    out_ready = 1'b0;
    gap_mode  = 1'b0;
    fifo_q.delete();
    step(2);
    rx_data.delete();
    rx_be.delete();
    rx_cyc.delete();
    pop_cyc.delete();
  endtask

  task automatic test_reset();
    @(negedge rclk);
    rrst_n = 1'b0;
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'h5A);
    step(3);
    total++; if (rinc !== 1'b0) begin bad++; $display("FAIL reset_rinc got=%b want=0", rinc); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=00000000", out_data); end
    total++; if (out_be !== 4'h0) begin bad++; $display("FAIL reset_be got=%h want=0", out_be); end
    total++; if (fifo_q.size() != 2) begin bad++; $display("FAIL reset_no_pop got=%0d want=2", fifo_q.size()); end
  endtask

  task automatic test_streaming();
    hold_reset();
    for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
    out_ready = 1'b1;
    step(1);
    rrst_n = 1'b1;
    for (int i = 0; i < 30 && rx_data.size() < 2; i++) step(1);
    step(2);
    total++;
    if (rx_data.size() != 2) begin
      bad++; $display("FAIL stream_count got=%0d want=2", rx_data.size());
    end else begin
      total++; if (rx_data[0] !== 32'h04030201) begin bad++; $display("FAIL stream_w0 got=%h want=04030201", rx_data[0]); end
      total++; if (rx_data[1] !== 32'h08070605) begin bad++; $display("FAIL stream_w1 got=%h want=08070605", rx_data[1]); end
      total++; if (rx_be[0] !== 4'hF || rx_be[1] !== 4'hF) begin bad++; $display("FAIL stream_be got=%h,%h want=f,f", rx_be[0], rx_be[1]); end
      total++; if (rx_cyc[1] - rx_cyc[0] != 4) begin bad++; $display("FAIL stream_spacing got=%0d want=4", rx_cyc[1] - rx_cyc[0]); end
    end
    total++;
    if (pop_cyc.size() != 8) begin
      bad++; $display("FAIL stream_pops got=%0d want=8", pop_cyc.size());
    end else begin
      total++; if (pop_cyc[7] - pop_cyc[0] != 7) begin bad++; $display("FAIL stream_rinc_run got=%0d want=7", pop_cyc[7] - pop_cyc[0]); end
      if (rx_cyc.size() > 0) begin
        total++; if (rx_cyc[0] - pop_cyc[3] != 1) begin bad++; $display("FAIL stream_latency got=%0d want=1", rx_cyc[0] - pop_cyc[3]); end
      end
    end
  endtask

  task automatic test_backpressure();
    hold_reset();
    for (int i = 0; i < 12; i++) fifo_q.push_back(8'h30 + 8'(i));
    step(1);
    rrst_n = 1'b1;
    step(14);
    for (int k = 0; k < 3; k++) begin
      total++; if (out_valid !== 1'b1 || out_data !== 32'h33323130 || out_be !== 4'hF) begin
        bad++; $display("FAIL bp_hold got=%b/%h/%h want=1/33323130/f", out_valid, out_data, out_be);
      end
      step(1);
    end
    total++; if (pop_cyc.size() != 8) begin bad++; $display("FAIL bp_pops got=%0d want=8", pop_cyc.size()); end
    total++; if (rinc !== 1'b0) begin bad++; $display("FAIL bp_rinc got=%b want=0", rinc); end
    out_ready = 1'b1;
    for (int i = 0; i < 30 && rx_data.size() < 3; i++) step(1);
    step(3);
    total++;
    if (rx_data.size() != 3) begin
      bad++; $display("FAIL bp_count got=%0d want=3", rx_data.size());
    end else begin
      total++; if (rx_data[0] !== 32'h33323130 || rx_data[1] !== 32'h37363534 || rx_data[2] !== 32'h3B3A3938) begin
        bad++; $display("FAIL bp_order got=%h %h %h want=33323130 37363534 3b3a3938", rx_data[0], rx_data[1], rx_data[2]);
      end
    end
  endtask

  task automatic test_empty_gaps();
    logic [31:0] exp_w[4];
    exp_w[0] = 32'h13121110; exp_w[1] = 32'h17161514;
    exp_w[2] = 32'h1B1A1918; exp_w[3] = 32'h1F1E1D1C;
    hold_reset();
    viol = 0;
    for (int i = 0; i < 16; i++) fifo_q.push_back(8'h10 + 8'(i));
    gap_mode  = 1'b1;
    out_ready = 1'b1;
    step(1);
    rrst_n = 1'b1;
    for (int i = 0; i < 120 && rx_data.size() < 4; i++) step(1);
    step(2);
    gap_mode = 1'b0;
    total++; if (viol != 0) begin bad++; $display("FAIL gap_rinc_on_empty got=%0d want=0", viol); end
    total++;
    if (rx_data.size() != 4) begin
      bad++; $display("FAIL gap_count got=%0d want=4", rx_data.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++; if (rx_data[k] !== exp_w[k]) begin bad++; $display("FAIL gap_word%0d got=%h want=%h", k, rx_data[k], exp_w[k]); end
      end
    end
  endtask

  task automatic test_timeout();
    hold_reset();
    fifo_q.push_back(8'hAA);
    fifo_q.push_back(8'hBB);
    fifo_q.push_back(8'hCC);
    out_ready = 1'b1;
    step(1);
    rrst_n = 1'b1;
`ifdef FIFO_RD_PACK_TIMEOUT_EN
    for (int i = 0; i < 60 && rx_data.size() < 1; i++) step(1);
    total++;
    if (rx_data.size() != 1 || pop_cyc.size() != 3) begin
      bad++; $display("FAIL tmo_flush got=%0d words,%0d pops want=1,3", rx_data.size(), pop_cyc.size());
    end else begin
      total++; if (rx_data[0] !== 32'h00CCBBAA) begin bad++; $display("FAIL tmo_data got=%h want=00ccbbaa", rx_data[0]); end
      total++; if (rx_be[0] !== 4'h7) begin bad++; $display("FAIL tmo_be got=%h want=7", rx_be[0]); end
      total++; if (rx_cyc[0] - pop_cyc[2] != 18) begin bad++; $display("FAIL tmo_delay got=%0d want=18", rx_cyc[0] - pop_cyc[2]); end
    end
`else
    step(100);
    total++; if (rx_data.size() != 0 || out_valid !== 1'b0) begin bad++; $display("FAIL tmo_none got=%0d,%b want=0,0", rx_data.size(), out_valid); end
    total++; if (pop_cyc.size() != 3) begin bad++; $display("FAIL tmo_pops got=%0d want=3", pop_cyc.size()); end
`endif
  endtask

  task automatic test_mid_reset();
    hold_reset();
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'h40 + 8'(i));
    step(1);
    rrst_n = 1'b1;
    step(12);
    total++; if (out_valid !== 1'b1 || out_data !== 32'h43424140) begin bad++; $display("FAIL mid_pre got=%b/%h want=1/43424140", out_valid, out_data); end
    rrst_n = 1'b0;
    step(1);
    total++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin bad++; $display("FAIL mid_drop got=%b/%h want=0/00000000", out_valid, out_data); end
    rx_data.delete();
    rx_be.delete();
    rx_cyc.delete();
    rrst_n = 1'b1;
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'h21 + 8'(i));
    out_ready = 1'b1;
    for (int i = 0; i < 20 && rx_data.size() < 1; i++) step(1);
    step(4);
    total++;
    if (rx_data.size() != 1) begin
      bad++; $display("FAIL mid_count got=%0d want=1", rx_data.size());
    end else begin
      total++; if (rx_data[0] !== 32'h24232221) begin bad++; $display("FAIL mid_word got=%h want=24232221", rx_data[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty_gaps();
    test_timeout();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
